// File: rtl/adc_sample_scheduler_pkg.sv
// adc_sample_scheduler_pkg: shared defaults, FSM encoding and channel-width helper
package adc_sample_scheduler_pkg;
  localparam int W_DATA_DEF = 18;
  localparam int N_CHAN_DEF = 8;
  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/adc_sample_scheduler_if.sv
// adc_sample_scheduler_if: sample handshake between the scheduler and the PID core
interface adc_sample_scheduler_if
  import adc_sample_scheduler_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int N_CHAN = N_CHAN_DEF
);
  localparam int W_CHAN = clog2_f(N_CHAN);
  logic                     data_valid_out;
  logic signed [W_DATA-1:0] data_out;
  logic [W_CHAN-1:0]        chan_out;
  logic                     core_ready_in;
  modport master (output data_valid_out, data_out, chan_out, input core_ready_in);
  modport slave (input data_valid_out, data_out, chan_out, output core_ready_in);
endinterface

// File: rtl/adc_sample_scheduler_rr_arbiter.sv
// rr_arbiter: grants the first requesting channel after the last grant, wrapping around
module rr_arbiter
  import adc_sample_scheduler_pkg::*;
#(
  parameter int N_CHAN = N_CHAN_DEF,
  localparam int W_CHAN = clog2_f(N_CHAN)
)(
  input  logic [N_CHAN-1:0] req,
  input  logic [W_CHAN-1:0] last,
  output logic              gnt_valid,
  output logic [W_CHAN-1:0] gnt_idx
);
  function automatic logic [W_CHAN-1:0] cand(input logic [W_CHAN-1:0] base, input int o);
    int v;
    v = int'(base) + o;
    return W_CHAN'(v >= N_CHAN ? v - N_CHAN : v);
  endfunction
  // scan from the farthest candidate to the nearest so the nearest requester wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    for (int o = N_CHAN; o >= 1; o--) begin
      if (req[cand(last, o)]) begin
        gnt_valid = 1'b1;
        gnt_idx = cand(last, o);
      end
    end
  end
endmodule

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: captures per-channel ADC samples and issues them round-robin to one PID core
module adc_sample_scheduler
  import adc_sample_scheduler_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int N_CHAN = N_CHAN_DEF,
  parameter logic [N_CHAN-1:0] EN_INIT = {N_CHAN{1'b1}},
  localparam int W_CHAN = clog2_f(N_CHAN)
)(
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [N_CHAN-1:0]     data_valid_in,
  input  logic [W_DATA-1:0]     data_a_in,
  input  logic [W_DATA-1:0]     data_b_in,
  input  logic [N_CHAN-1:0]     chan_en_in,
  input  logic                  update_in,
  input  logic                  ovr_clr_in,
  adc_sample_scheduler_if.master pid,
  output logic [N_CHAN-1:0]     overrun_out
);
  localparam int HALF = N_CHAN / 2;
  state_t st, st_n;
  logic [N_CHAN-1:0] en_mask, pending, cap, ovr_set, ld_mask;
  logic [W_DATA-1:0] slot [N_CHAN];
  logic [W_CHAN-1:0] last_grant, gnt_idx;
  logic gnt_valid, load;
  rr_arbiter #(.N_CHAN(N_CHAN)) u_arb (
    .req(pending & en_mask),
    .last(last_grant),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );
  // FSM state register; reset drops any in-flight sample at once
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) st <= ST_IDLE;
    else st <= st_n;
  // a winner loads when idle, or when the core takes the current sample
  always_comb begin
    load = gnt_valid && (st == ST_IDLE || pid.core_ready_in);
    st_n = (st == ST_ISSUE && !pid.core_ready_in) ? ST_ISSUE : (gnt_valid ? ST_ISSUE : ST_IDLE);
    pid.data_valid_out = st == ST_ISSUE;
  end
  // captures this edge; a recapture of the channel being loaded is not an overrun
  always_comb begin
    cap = data_valid_in & en_mask;
    ld_mask = '0;
    if (load) ld_mask[gnt_idx] = 1'b1;
    ovr_set = cap & pending & ~ld_mask;
  end
  // slots, pending flags, enable mask, overrun flags and the issue registers
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      for (int i = 0; i < N_CHAN; i++) slot[i] <= '0;
      pending <= '0;
      en_mask <= EN_INIT;
      last_grant <= W_CHAN'(N_CHAN - 1);
      overrun_out <= '0;
      pid.data_out <= '0;
      pid.chan_out <= '0;
    end else begin
      if (load) begin
        pid.data_out <= slot[gnt_idx];
        pid.chan_out <= gnt_idx;
        last_grant <= gnt_idx;
      end
      for (int i = 0; i < N_CHAN; i++)
        if (cap[i]) slot[i] <= (i < HALF) ? data_a_in : data_b_in;
      pending <= ((pending & ~ld_mask) | cap) & (update_in ? chan_en_in : '1);
      if (update_in) en_mask <= chan_en_in;
      overrun_out <= (ovr_clr_in ? '0 : overrun_out) | ovr_set;
    end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: directed plan scenarios plus random traffic against a queue-free behavioural model
module tb_adc_sample_scheduler;
  localparam int N = 8;
  localparam int W = 18;
  localparam int H = N / 2;
  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  logic [N-1:0] data_valid_in = '0;
  logic [N-1:0] chan_en_in = '1;
  logic [N-1:0] overrun_out;
  logic [W-1:0] data_a_in = '0;
  logic [W-1:0] data_b_in = '0;
  logic update_in = 1'b0;
  logic ovr_clr_in = 1'b0;
  int n_tests, n_fail;
  logic [W-1:0] m_slot [N];
  logic [N-1:0] m_pend, m_en, m_ovr;
  int m_last, m_chan;
  logic m_valid;
  logic [W-1:0] m_data;

  adc_sample_scheduler_if #(.W_DATA(W), .N_CHAN(N)) pid ();

  adc_sample_scheduler #(.W_DATA(W), .N_CHAN(N), .EN_INIT({N{1'b1}})) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .data_valid_in(data_valid_in),
    .data_a_in(data_a_in),
    .data_b_in(data_b_in),
    .chan_en_in(chan_en_in),
    .update_in(update_in),
    .ovr_clr_in(ovr_clr_in),
    .pid(pid.master),
    .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_slot[i] = '0;
    m_pend = '0;
    m_en = '1;
    m_ovr = '0;
    m_last = N - 1;
    m_valid = 1'b0;
    m_data = '0;
    m_chan = 0;
  endtask

  task automatic model_step();
    logic any, ld;
    int w;
    logic [N-1:0] setb;
    any = 1'b0;
    w = 0;
    for (int o = 1; o <= N && !any; o++)
      if (m_pend[(m_last + o) % N] && m_en[(m_last + o) % N]) begin
        any = 1'b1;
        w = (m_last + o) % N;
      end
    ld = any && (!m_valid || pid.core_ready_in);
    m_valid = (m_valid && !pid.core_ready_in) || any;
    if (ld) begin
      m_data = m_slot[w];
      m_chan = w;
      m_pend[w] = 1'b0;
      m_last = w;
    end
    setb = '0;
    for (int i = 0; i < N; i++)
      if (data_valid_in[i] && m_en[i]) begin
        if (m_pend[i]) setb[i] = 1'b1;
        m_slot[i] = (i < H) ? data_a_in : data_b_in;
        m_pend[i] = 1'b1;
      end
    m_ovr = ovr_clr_in ? setb : (m_ovr | setb);
    if (update_in) begin
      m_pend = m_pend & chan_en_in;
      m_en = chan_en_in;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    check("valid", pid.data_valid_out, m_valid);
    if (m_valid) begin
      check("data", $unsigned(pid.data_out), m_data);
      check("chan", pid.chan_out, m_chan);
    end
    check("overrun", overrun_out, m_ovr);
  endtask

  task automatic drive(input logic [N-1:0] dv, input logic rdy);
    data_valid_in = dv;
    pid.core_ready_in = rdy;
    tick();
    data_valid_in = '0;
    update_in = 1'b0;
    ovr_clr_in = 1'b0;
  endtask

  initial begin
    logic [H-1:0] r;
    n_tests = 0;
    n_fail = 0;
    pid.core_ready_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    check("rst_valid", pid.data_valid_out, 0);
    check("rst_data", $unsigned(pid.data_out), 0);
    check("rst_chan", pid.chan_out, 0);
    check("rst_ovr", overrun_out, 0);
    @(negedge clk_in);
    reset_in = 1'b0;

    data_a_in = 18'h00123;
    data_b_in = 18'h3FFFF;
    drive(8'h11, 1'b1);
    check("sc_latency", pid.data_valid_out, 0);
    drive(8'h00, 1'b1);
    check("sc_chan0", pid.chan_out, 0);
    check("sc_data0", $unsigned(pid.data_out), 18'h00123);
    drive(8'h00, 1'b1);
    check("sc_chan4", pid.chan_out, 4);
    check("sc_data4", $unsigned(pid.data_out), 18'h3FFFF);
    drive(8'h00, 1'b1);
    check("sc_drop", pid.data_valid_out, 0);

    data_a_in = 18'h00ABC;
    drive(8'h03, 1'b0);
    drive(8'h00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(8'h00, 1'b0);
      check("bp_chan", pid.chan_out, 0);
      check("bp_data", $unsigned(pid.data_out), 18'h00ABC);
    end
    drive(8'h00, 1'b1);
    check("bp_next", pid.chan_out, 1);
    drive(8'h00, 1'b1);
    check("bp_drop", pid.data_valid_out, 0);

    drive(8'h04, 1'b1);
    drive(8'h00, 1'b0);
    drive(8'hFF, 1'b0);
    for (int k = 0; k < N; k++) begin
      drive(8'h00, 1'b1);
      check("rr_order", pid.chan_out, (3 + k) % N);
    end
    drive(8'h00, 1'b1);
    check("rr_drop", pid.data_valid_out, 0);

    drive(8'h01, 1'b0);
    drive(8'h00, 1'b0);
    data_a_in = 18'h11111;
    drive(8'h04, 1'b0);
    data_a_in = 18'h22222;
    drive(8'h04, 1'b0);
    check("ovr_flag", overrun_out, 8'h04);
    drive(8'h00, 1'b1);
    check("ovr_chan", pid.chan_out, 2);
    check("ovr_data", $unsigned(pid.data_out), 18'h22222);
    ovr_clr_in = 1'b1;
    drive(8'h00, 1'b1);
    check("ovr_clr", overrun_out, 0);

    drive(8'h08, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h60, 1'b0);
    chan_en_in = 8'h0F;
    update_in = 1'b1;
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b1);
    check("en_dropped", pid.data_valid_out, 0);
    drive(8'hFF, 1'b1);
    for (int k = 0; k < H; k++) begin
      drive(8'h00, 1'b1);
      check("en_served", pid.chan_out, k);
    end
    drive(8'h00, 1'b1);
    check("en_ignored", pid.data_valid_out, 0);
    chan_en_in = '1;
    update_in = 1'b1;
    drive(8'h00, 1'b1);

    drive(8'h01, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h01, 1'b0);
    drive(8'h01, 1'b0);
    check("ar_pre_ovr", overrun_out, 8'h01);
    check("ar_pre_valid", pid.data_valid_out, 1);
    #2 reset_in = 1'b1;
    #1;
    check("ar_valid", pid.data_valid_out, 0);
    check("ar_ovr", overrun_out, 0);
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
    drive(8'hFF, 1'b1);
    drive(8'h00, 1'b1);
    check("ar_first", pid.chan_out, 0);

    for (int c = 0; c < 3000; c++) begin
      r = H'($urandom);
      data_a_in = W'($urandom);
      data_b_in = W'($urandom);
      update_in = $urandom_range(0, 40) == 0;
      if (update_in) chan_en_in = N'($urandom);
      ovr_clr_in = $urandom_range(0, 30) == 0;
      drive(($urandom_range(0, 2) == 0) ? {r, r} : '0, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Sits between the ADC serial read controller and the single shared PID core. Captures each ADC channel sample as its valid pulse arrives, holds it in a per-channel slot, and issues the samples one at a time to the PID core through a valid/ready handshake. Uses round-robin order across enabled channels and flags per-channel overruns. Lets one PID datapath serve all N_CHAN ADC channels.

## Interface
- W_DATA, 18, sample width (signed)
- N_CHAN, 8, number of ADC channels; even, ≥2
- EN_INIT, {N_CHAN{1'b1}}, channel enable mask after reset
- W_CHAN (localparam), clog2(N_CHAN), channel index width

- clk_in  in  1  system/ADC clock; all logic on posedge
- reset_in  in  1  reset, asynchronous, active-high
- data_valid_in  in  N_CHAN  per-channel sample strobes; bits i and i+N_CHAN/2 pulse together
- data_a_in  in  W_DATA  channel-A serial port word (channels 0..N_CHAN/2-1)
- data_b_in  in  W_DATA  channel-B serial port word (channels N_CHAN/2..N_CHAN-1)
- chan_en_in  in  N_CHAN  requested enable mask from frontpanel
- update_in  in  1  pulse: latch chan_en_in into the active mask
- ovr_clr_in  in  1  pulse: clear all overrun flags
- core_ready_in  in  1  PID core accepts the current sample
- data_valid_out  out  1  sample on data_out/chan_out is valid
- data_out  out  W_DATA  signed sample to PID core
- chan_out  out  W_CHAN  channel index of data_out
- overrun_out  out  N_CHAN  sticky per-channel overrun flags

## Operation
- Capture: on an edge with data_valid_in[i]=1 and en_mask[i]=1:
  - slot[i] <= data_a_in for i<N_CHAN/2; slot[i] <= data_b_in otherwise
  - pending[i] <= 1
  - Strobes for disabled channels are ignored.
- Overrun: capture into a slot with pending[i]=1 that is not being issued on the same edge. The new sample overwrites the slot and sets overrun_out[i].
- Eligible set: pending & en_mask. Round-robin winner is the first eligible index after last_grant, wrapping modulo N_CHAN.
- FSM states:
  - ST_IDLE: if any channel is eligible, load the winner, then go to ST_ISSUE.
  - ST_ISSUE: data_valid_out=1, outputs held stable. On an edge with core_ready_in=1:
    - if another channel is eligible, load the next winner and stay in ST_ISSUE
    - otherwise go to ST_IDLE
- Load of winner k, all on one edge:
  - data_out <= slot[k], chan_out <= k
  - pending[k] <= 0, last_grant <= k
- Load and capture of the same channel k on one edge: the output takes the old slot value. Slot takes the new value, pending[k] stays 1, no overrun.
- update_in:
  - en_mask <= chan_en_in
  - pending bits of newly disabled channels clear on the same edge
  - a sample already in ST_ISSUE completes normally
- ovr_clr_in: overrun_out <= 0. A simultaneous new overrun wins, so the flag stays set.
- Reset values:
  - outputs: data_valid_out=0, data_out=0, chan_out=0, overrun_out=0
  - internal: pending=0, slots=0, en_mask=EN_INIT, last_grant=N_CHAN-1 (channel 0 served first), state ST_IDLE
- Reset mid-handshake: the in-flight sample is dropped and data_valid_out falls asynchronously.

## Timing
- Capture-to-issue latency: strobe sampled at edge E0 → data_valid_out=1 after E1, when idle.
- Throughput: one sample per cycle while core_ready_in=1 and work is pending.
- data_out and chan_out change only on a load edge. They never change while data_valid_out=1 and core_ready_in=0.
- core_ready_in is ignored in ST_IDLE.
- The core has at least N_CHAN/2·W_DATA cycles per ADC frame to drain. Slower draining produces overruns, never stalls.

## Structure
- Shared package:
  - W_DATA and N_CHAN defaults
  - state encodings ST_IDLE and ST_ISSUE
  - W_CHAN clog2 function
- Sub-module rr_arbiter (combinational): inputs req[N_CHAN] and last[W_CHAN]; outputs gnt_valid and gnt_idx. This block instantiates it once.

## Test plan
- Single capture: reset, pulse data_valid_in=8'h11 with data_a_in=18'h00123, data_b_in=18'h3FFFF, core_ready_in=1.
  - → chan 0 with 18'h00123, then chan 4 with 18'h3FFFF, on consecutive cycles; data_valid_out drops after.
- Backpressure: core_ready_in=0 for 10 cycles with channels 0 and 1 pending.
  - → data_out and chan_out=0 held stable for all 10 cycles.
  - → on ready, chan 1 follows on the next cycle.
- Round-robin: all 8 pending, last_grant=2.
  - → issue order 3,4,5,6,7,0,1,2.
- Overrun: two strobes on channel 2 before it is issued (ready=0).
  - → overrun_out=8'h04; issued value is the second sample.
  - → ovr_clr_in clears the flag.
- Enable mask: chan_en_in=8'h0F with update_in while channels 5 and 6 are pending.
  - → pending 5 and 6 dropped.
  - → later strobes on 4–7 ignored; 0–3 still served.
- Async reset asserted while in ST_ISSUE.
  - → data_valid_out=0 immediately, overrun_out=0.
  - → first grant after release is channel 0.
